afp_pack: RTL
=============

AFP_PACK -- requirements
Module: afp_pack

Interface
REQ-001 Parameter CNT_W, default 8, width of the saturating overflow-event counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  unpacked product presented this cycle.
REQ-005 in_ready  output  1  block accepts the product this cycle.
REQ-006 ps  input  1  product sign.
REQ-007 po  input  3  unbiased product exponent sum, 0..6.
REQ-008 pm  input  4  unnormalized product mantissa, binary point between bits 2 and 1.
REQ-009 out_valid  output  1  packed result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  4  packed AFP word {sign, exp[1:0], man}; exp 2'b11 is the zero/denormal code.
REQ-012 out_ovf  output  1  the result presented on out_data was saturated.
REQ-013 ovf_cnt  output  CNT_W  count of saturated results delivered.

Function
REQ-014 The block SHALL be a two-stage pipeline. Stage 1 registers the leading-one position, the selected mantissa bit, the guard bit and the adjusted exponent. Stage 2 registers out_data and out_ovf.
REQ-015 A global advance enable SHALL be defined as en = out_ready | ~out_valid, and in_ready SHALL equal en.
REQ-016 Both stages SHALL load only when en=1. Stage-1 valid loads in_valid; stage-2 valid (out_valid) loads stage-1 valid.
REQ-017 Latency from input handshake to out_valid SHALL be 2 cycles when out_ready=1; throughput 1 per cycle.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_ovf and out_valid SHALL hold stable.
REQ-019 Normalization SHALL select the case by the leading bits of pm:
- pm[3]=1: man=pm[2], guard=pm[1], e=po+1.
- pm[3:2]=01: man=pm[1], guard=pm[0], e=po.
- pm[3:2]=00 and pm!=0: exp code 2'b11, man=pm[1] (denormal).
- pm=0: exp code 2'b11, man=0 (zero).
REQ-020 Exponent e SHALL be computed 3 bits wide, with no wrap.
REQ-021 For normal results, e<=2 SHALL encode exp=e[1:0].
REQ-022 For normal results, e>=3 SHALL saturate to exp=2'b10, man=1 and set out_ovf=1.
REQ-023 The sign bit SHALL pass through unchanged in every case, including zero.
REQ-024 ovf_cnt SHALL increment by one on each output handshake (out_valid & out_ready) carrying out_ovf=1.
REQ-025 ovf_cnt SHALL saturate at all-ones and not wrap.
REQ-026 An input handshake and an output handshake in the same cycle SHALL both complete, with no bubble inserted.

Reset
REQ-027 On reset=1 at a clock edge, the following SHALL clear to 0 regardless of handshake state: both stage valids, out_valid, out_data, out_ovf and ovf_cnt.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Data in flight when reset asserts mid-operation SHALL be discarded, with no output handshake.

Configuration
REQ-030 With macro AFP_PACK_ROUND_EN defined, normal results SHALL round half-up on the guard bit.
REQ-031 Under AFP_PACK_ROUND_EN, a mantissa carry SHALL set man=0 and increment e before the saturation check of REQ-022.
REQ-032 Without AFP_PACK_ROUND_EN, the guard bit SHALL be ignored (truncation), and the guard register SHALL not be synthesized.

Structure
REQ-033 Package afp_pkg SHALL hold:
- the afp_word_t packed typedef;
- constant AFP_EXP_DENORM=2'b11;
- constant AFP_EXP_MAX=2'b10.
The multiplier and this block SHALL share afp_pkg.
REQ-034 Leading-one detection and case select SHALL be the sub-module afp_lzd, which is combinational and instanced in stage 1.

Verification
REQ-035 The bench SHALL cover ps=1, po=3'd1, pm=4'b1001, out_ready=1 -> after 2 cycles out_data=4'b1100, out_ovf=0.
REQ-036 The bench SHALL cover ps=0, po=0, pm=4'b0110 -> out_data=4'b0001; and pm=4'b0000, ps=1 -> out_data=4'b1110.
REQ-037 The bench SHALL cover ps=0, po=3'd2, pm=4'b1001 -> out_data=4'b0101, out_ovf=1; ovf_cnt 0->1 on handshake; 2^CNT_W+3 such results leave ovf_cnt all-ones.
REQ-038 The bench SHALL cover AFP_PACK_ROUND_EN, ps=0, po=0, pm=4'b0111 -> out_data=4'b0010. Without the macro, the same input -> 4'b0001.
REQ-039 The bench SHALL cover out_ready=0 while 3 inputs are offered:
- in_ready falls after 2 accepted;
- out_data is held stable;
- after out_ready=1, results drain in order, one per cycle.
REQ-040 The bench SHALL cover reset asserted for 1 cycle with out_valid=1 and a stage-1 item pending -> next cycle out_valid=0, ovf_cnt=0, in_ready=1, and no stale output appears.

Source files
------------

// File: rtl/afp_pkg.sv
// Shared AFP word format and normalization case codes, used by the multiplier and afp_pack.
package afp_pkg;

    typedef struct packed {
        logic       sign;
        logic [1:0] exp;
        logic       man;
    } afp_word_t;

    localparam logic [1:0] AFP_EXP_DENORM = 2'b11;
    localparam logic [1:0] AFP_EXP_MAX    = 2'b10;

    // Position of the leading one in the raw product mantissa
    typedef enum logic [1:0] {
        LZD_NORM_HI = 2'b00,
        LZD_NORM_LO = 2'b01,
        LZD_DENORM  = 2'b10,
        LZD_ZERO    = 2'b11
    } lzd_case_t;

endpackage

// File: rtl/afp_lzd.sv
// Combinational leading-one detect and case select for the raw product mantissa.
// The guard output exists only when AFP_PACK_ROUND_EN is defined.
module afp_lzd
    import afp_pkg::*;
(
    input  logic [3:0] i_pm,
    input  logic [2:0] i_po,
    output lzd_case_t  o_case,
    output logic       o_man,
`ifdef AFP_PACK_ROUND_EN
    output logic       o_guard,
`endif
    output logic [2:0] o_exp
);

    logic w_guard;

    always_comb begin
        o_case  = LZD_ZERO;
        o_man   = 1'b0;
        o_exp   = i_po;
        w_guard = 1'b0;
        if (i_pm[3]) begin
            o_case  = LZD_NORM_HI;
            o_man   = i_pm[2];
            w_guard = i_pm[1];
            // Clamp instead of wrapping; any exponent >= 3 saturates downstream anyway
            o_exp   = (&i_po) ? i_po : i_po + 3'd1;
        end else if (i_pm[2]) begin
            o_case  = LZD_NORM_LO;
            o_man   = i_pm[1];
            w_guard = i_pm[0];
        end else if (i_pm != 4'd0) begin
            o_case  = LZD_DENORM;
            o_man   = i_pm[1];
        end
    end

`ifdef AFP_PACK_ROUND_EN
    assign o_guard = w_guard;
`else
    logic w_unused;
    assign w_unused = w_guard;
`endif

endmodule

// File: rtl/afp_pack.sv
// Two-stage normalize/pack of an unpacked AFP product into a 4-bit AFP word.
// Define AFP_PACK_ROUND_EN to round half-up on the guard bit (default: truncate).
module afp_pack
    import afp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ps,
    input  logic [2:0]       po,
    input  logic [3:0]       pm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef AFP_PACK_ROUND_EN
    // Returns {exp4, man}; a mantissa carry bumps the exponent and clears man
    function automatic logic [4:0] f_round(input logic m, input logic g, input logic [2:0] e);
        logic [3:0] e4;
        e4 = {1'b0, e};
        if (m & g) f_round = {e4 + 4'd1, 1'b0};
        else       f_round = {e4, m | g};
    endfunction
`endif

    function automatic afp_word_t f_sat_pack(input logic s, input lzd_case_t c, input logic m,
                                             input logic [3:0] e, output logic ovf);
        afp_word_t w;
        w.sign = s;
        w.exp  = AFP_EXP_DENORM;
        w.man  = m;
        ovf    = 1'b0;
        if ((c == LZD_NORM_HI) || (c == LZD_NORM_LO)) begin
            if (e >= 4'd3) begin
                w.exp = AFP_EXP_MAX;
                w.man = 1'b1;
                ovf   = 1'b1;
            end else begin
                w.exp = e[1:0];
            end
        end
        return w;
    endfunction

    logic       w_en;
    lzd_case_t  w_case;
    logic       w_man;
    logic [2:0] w_exp;

    logic       r_vld_p1;
    logic       r_sgn_p1;
    lzd_case_t  r_case_p1;
    logic       r_man_p1;
    logic [2:0] r_exp_p1;
`ifdef AFP_PACK_ROUND_EN
    logic       w_grd;
    logic       r_grd_p1;
`endif

    logic       r_vld_p2;
    afp_word_t  r_word_p2;
    logic       r_ovf_p2;
    logic [CNT_W-1:0] r_ovf_cnt;

    assign w_en      = out_ready | ~r_vld_p2;
    assign in_ready  = w_en;
    assign out_valid = r_vld_p2;
    assign out_data  = r_word_p2;
    assign out_ovf   = r_ovf_p2;
    assign ovf_cnt   = r_ovf_cnt;

    afp_lzd u_lzd (
        .i_pm    (pm),
        .i_po    (po),
        .o_case  (w_case),
        .o_man   (w_man),
`ifdef AFP_PACK_ROUND_EN
        .o_guard (w_grd),
`endif
        .o_exp   (w_exp)
    );

    // Stage 1: leading-one case, selected mantissa bit, guard and adjusted exponent
    always_ff @(posedge clk) begin
        if (reset)     r_vld_p1 <= 1'b0;
        else if (w_en) r_vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_sgn_p1  <= ps;
            r_case_p1 <= w_case;
            r_man_p1  <= w_man;
            r_exp_p1  <= w_exp;
`ifdef AFP_PACK_ROUND_EN
            r_grd_p1  <= w_grd;
`endif
        end
    end

    logic [3:0] w_exp4_p1;
    logic       w_man_p1;
    afp_word_t  w_word_p1;
    logic       w_ovf_p1;

    always_comb begin
        w_exp4_p1 = {1'b0, r_exp_p1};
        w_man_p1  = r_man_p1;
`ifdef AFP_PACK_ROUND_EN
        if ((r_case_p1 == LZD_NORM_HI) || (r_case_p1 == LZD_NORM_LO))
            {w_exp4_p1, w_man_p1} = f_round(r_man_p1, r_grd_p1, r_exp_p1);
`endif
        w_word_p1 = f_sat_pack(r_sgn_p1, r_case_p1, w_man_p1, w_exp4_p1, w_ovf_p1);
    end

    // Stage 2: packed word and overflow flag; output data is cleared on reset too
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_word_p2 <= '0;
            r_ovf_p2  <= 1'b0;
        end else if (w_en) begin
            r_vld_p2  <= r_vld_p1;
            r_word_p2 <= w_word_p1;
            r_ovf_p2  <= w_ovf_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_ovf_cnt <= '0;
        else if (r_vld_p2 && out_ready && r_ovf_p2 && (r_ovf_cnt != CNT_MAX))
            r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
    end

endmodule
